// File: rtl/integer_to_float.sv
// Three-stage signed int32 -> IEEE-754 single converter with valid/ready handshake.
// Optional rounding-mode port enabled by defining I2F_ROUND_MODE_EN (default: RNE only).
module integer_to_float (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_a,
`ifdef I2F_ROUND_MODE_EN
    input  logic [1:0]  i_rm,
`endif
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_d,
    output logic        o_p_lost
);

    logic        r_v1, r_v2, r_v3;
    logic        r_sign1, r_sign2;
    logic [31:0] r_mag1;
    logic [1:0]  r_rm1, r_rm2;
    logic [30:0] r_m2;
    logic [7:0]  r_exp2;
    logic        r_zero2;
    logic [31:0] r_d;
    logic        r_p_lost;

    logic        w_adv1, w_adv2, w_adv3;
    logic        w_sign;
    logic [31:0] w_mag;
    logic [1:0]  w_rm;
    logic [4:0]  w_lz;
    logic        w_found;
    logic [31:0] w_m;
    logic [7:0]  w_exp;
    logic        w_g, w_s, w_inexact, w_up;
    logic [30:0] w_sum;

    assign w_adv3      = i_out_ready | ~r_v3;
    assign w_adv2      = w_adv3 | ~r_v2;
    assign w_adv1      = w_adv2 | ~r_v1;
    assign o_in_ready  = ~i_rst & w_adv1;
    assign o_out_valid = r_v3;
    assign o_d         = r_d;
    assign o_p_lost    = r_p_lost;

`ifdef I2F_ROUND_MODE_EN
    assign w_rm = i_rm;
`else
    assign w_rm = 2'b00;
`endif

    // S1: sign and magnitude; 0x80000000 maps onto itself as an unsigned magnitude
    assign w_sign = i_a[31];
    assign w_mag  = w_sign ? (~i_a + 32'd1) : i_a;

    // S2: leading-zero count and normalize
    always_comb begin
        w_lz    = 5'd0;
        w_found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!w_found) begin
                if (r_mag1[i]) w_found = 1'b1;
                else           w_lz    = w_lz + 5'd1;
            end
        end
    end

    assign w_m   = r_mag1 << w_lz;
    assign w_exp = 8'd158 - {3'd0, w_lz};

    // S3: round; a carry out of the fraction increments the exponent through the sum
    assign w_g       = r_m2[7];
    assign w_s       = |r_m2[6:0];
    assign w_inexact = w_g | w_s;

    always_comb begin
        w_up = 1'b0;
        case (r_rm2)
            2'b00:   w_up = w_g & (w_s | r_m2[8]);
            2'b01:   w_up = 1'b0;
            2'b10:   w_up = r_sign2 & w_inexact;
            default: w_up = ~r_sign2 & w_inexact;
        endcase
    end

    assign w_sum = {r_exp2, r_m2[30:8]} + {30'd0, w_up};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_d      <= 32'd0;
            r_p_lost <= 1'b0;
        end else if (i_flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= i_in_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
            if (w_adv3 && r_v2) begin
                r_d      <= r_zero2 ? 32'd0 : {r_sign2, w_sum};
                r_p_lost <= r_zero2 ? 1'b0 : w_inexact;
            end
        end
    end

    // Datapath registers need no reset; the valid bits qualify them
    always_ff @(posedge i_clk) begin
        if (w_adv1 && i_in_valid) begin
            r_sign1 <= w_sign;
            r_mag1  <= w_mag;
            r_rm1   <= w_rm;
        end
        if (w_adv2 && r_v1) begin
            r_sign2 <= r_sign1;
            r_m2    <= w_m[30:0];
            r_exp2  <= w_exp;
            r_zero2 <= ~w_m[31];
            r_rm2   <= r_rm1;
        end
    end

endmodule
